seq_detect_param: RTL and testbench

//  Parametrised serial pattern detector, successor to the fixed 3-bit-state sequence FSM.

---
 rtl/seq_detect_param.sv | 122 ++++++++++++
 tb/tb_seq_detect_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// seq_detect_param : synchronised serial pattern detector with KMP-style
//                    progress state and a saturating match counter.
// Revision: 1.0
// ============================================================================
module seq_detect_param #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     SYNC_STAGES = 2,
  parameter int                     CNT_W       = 8,
  localparam int                    SW          = $clog2(PATTERN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next,
  input  logic             in,
  input  logic             clear,
  output logic [SW-1:0]    state_display,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  // Bit idx of the pattern in arrival order (idx 0 is the MSB).
  function automatic logic pat_bit(input int idx);
    logic [PATTERN_LEN-1:0] sh;
    sh = PATTERN >> (PATTERN_LEN - 1 - idx);
    return sh[0];
  endfunction

  function automatic int calc_border();
    int  best;
    logic ok;
    best = 0;
    for (int b = 1; b < PATTERN_LEN; b++) begin
      ok = 1'b1;
      for (int i = 0; i < PATTERN_LEN; i++) begin
        if (i < b && pat_bit(i) != pat_bit(PATTERN_LEN - b + i)) ok = 1'b0;
      end
      if (ok) best = b;
    end
    return best;
  endfunction

  // History is pattern prefix of length st followed by b; find the longest
  // pattern prefix that is a suffix of that history.
  function automatic int kmp_next(input int st, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic sb;
    best = 0;
    for (int k = 1; k <= PATTERN_LEN; k++) begin
      ok = (k <= st + 1);
      for (int i = 0; i < PATTERN_LEN; i++) begin
        if (ok && i < k) begin
          idx = st + 1 - k + i;
          sb  = (idx < st) ? pat_bit(idx) : b;
          if (pat_bit(i) != sb) ok = 1'b0;
        end
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  localparam int BORDER = calc_border();

  logic [SYNC_STAGES-1:0] next_sync_q;
  logic [SYNC_STAGES-1:0] in_sync_q;
  logic                   next_prev_q;
  logic [SW-1:0]          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]          base;
  logic                   step;
  logic                   in_bit;
  int                     nxt_state;

  assign step   = next_sync_q[SYNC_STAGES-1] & ~next_prev_q;
  assign in_bit = in_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_sync_q <= '0;
      in_sync_q   <= '0;
      next_prev_q <= 1'b0;
      state_q     <= '0;
      cnt_q       <= '0;
    end else begin
      next_sync_q <= {next_sync_q[SYNC_STAGES-2:0], next};
      in_sync_q   <= {in_sync_q[SYNC_STAGES-2:0], in};
      next_prev_q <= next_sync_q[SYNC_STAGES-1];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  // A completed match restarts from the pattern border or from empty.
  assign base = (state_q == SW'(PATTERN_LEN)) ? (OVERLAP ? SW'(BORDER) : '0) : state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nxt_state = 0;
    if (clear) begin
      state_d = '0;
    end else if (step) begin
      nxt_state = kmp_next(int'(base), in_bit);
      state_d   = SW'(nxt_state);
      if (nxt_state == PATTERN_LEN && cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign state_display = state_q;
  assign out           = (state_q == SW'(PATTERN_LEN));
  assign match_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// tb_seq_detect_param : directed self-checking bench for seq_detect_param.
// Revision: 1.0
// ============================================================================
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       r_reset, r_next, r_in, r_clear;
  logic [2:0] w_st1, w_st0, w_stc;
  logic       w_out1, w_out0, w_outc;
  logic [7:0] w_cnt1, w_cnt0;
  logic [1:0] w_cntc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.OVERLAP(1'b1)) u_ov1 (
    .clk(clk), .reset(r_reset), .next(r_next), .in(r_in), .clear(r_clear),
    .state_display(w_st1), .out(w_out1), .match_count(w_cnt1));

  seq_detect_param #(.OVERLAP(1'b0)) u_ov0 (
    .clk(clk), .reset(r_reset), .next(r_next), .in(r_in), .clear(r_clear),
    .state_display(w_st0), .out(w_out0), .match_count(w_cnt0));

  seq_detect_param #(.OVERLAP(1'b1), .CNT_W(2)) u_c2 (
    .clk(clk), .reset(r_reset), .next(r_next), .in(r_in), .clear(r_clear),
    .state_display(w_stc), .out(w_outc), .match_count(w_cntc));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    r_reset = 1'b0;
    repeat (2) @(negedge clk);
    r_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    r_in   = b;
    r_next = 1'b1;
    repeat (4) @(negedge clk);
    r_next = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int t2_bits[11] = '{0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0};
  int t2_exp [11] = '{0, 1, 2, 3, 4, 2, 0, 0, 1, 1, 2};
  int t3_bits[7]  = '{1, 0, 1, 1, 0, 1, 1};
  int t3_ov1 [7]  = '{1, 2, 3, 4, 2, 3, 4};
  int t3_ov0 [7]  = '{1, 2, 3, 4, 0, 1, 1};
  int t6_cnt [4]  = '{2, 3, 3, 3};

  initial begin
    r_reset = 1'b0;
    r_next  = 1'b0;
    r_in    = 1'b0;
    r_clear = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    r_reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_state", 32'(w_st1), 0);
    check_eq("rst_out",   32'(w_out1), 0);
    check_eq("rst_cnt",   32'(w_cnt1), 0);
    check_eq("rst_cnt_c2", 32'(w_cntc), 0);

    // Overlapping walk through a mixed stream
    for (int i = 0; i < 11; i++) begin
      send_bit(t2_bits[i][0]);
      check_eq($sformatf("t2_state[%0d]", i), 32'(w_st1), t2_exp[i]);
      check_eq($sformatf("t2_out[%0d]", i), 32'(w_out1), (t2_exp[i] == 4) ? 1 : 0);
    end
    check_eq("t2_cnt", 32'(w_cnt1), 1);

    // Overlap versus non-overlap restart
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send_bit(t3_bits[i][0]);
      check_eq($sformatf("t3_ov1[%0d]", i), 32'(w_st1), t3_ov1[i]);
      check_eq($sformatf("t3_ov0[%0d]", i), 32'(w_st0), t3_ov0[i]);
    end
    check_eq("t3_cnt_ov1", 32'(w_cnt1), 2);
    check_eq("t3_cnt_ov0", 32'(w_cnt0), 1);

    // Latency and single step on a held button
    do_reset();
    @(negedge clk);
    r_in   = 1'b1;
    r_next = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t4_before_lat", 32'(w_st1), 0);
    @(negedge clk);
    check_eq("t4_at_lat", 32'(w_st1), 1);
    repeat (37) @(negedge clk);
    check_eq("t4_held", 32'(w_st1), 1);
    r_next = 1'b0;
    repeat (4) @(negedge clk);

    // Button activity during reset, then held across release
    r_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) r_next = 1'b1;
      repeat (2) @(negedge clk);
      r_next = 1'b0;
      @(negedge clk);
    end
    check_eq("t4_in_reset", 32'(w_st1), 0);
    r_next = 1'b1;
    repeat (2) @(negedge clk);
    r_reset = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t4_across_rel", 32'(w_st1), 1);
    r_next = 1'b0;
    repeat (4) @(negedge clk);

    // Clear colliding with a step from state 3
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1);
    check_eq("t5_pre_state", 32'(w_st1), 3);
    check_eq("t5_pre_cnt", 32'(w_cnt1), 1);
    @(negedge clk);
    r_in   = 1'b1;
    r_next = 1'b1;
    repeat (2) @(negedge clk);
    r_clear = 1'b1;
    @(negedge clk);
    r_clear = 1'b0;
    check_eq("t5_state", 32'(w_st1), 0);
    check_eq("t5_out", 32'(w_out1), 0);
    check_eq("t5_cnt", 32'(w_cnt1), 1);
    repeat (3) @(negedge clk);
    check_eq("t5_step_dropped", 32'(w_st1), 0);
    r_next = 1'b0;
    repeat (4) @(negedge clk);

    // Counter saturation at CNT_W=2
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check_eq("t6_cnt[0]", 32'(w_cntc), 1);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      check_eq($sformatf("t6_cnt[%0d]", i + 1), 32'(w_cntc), t6_cnt[i]);
    end
    check_eq("t6_state", 32'(w_stc), 4);
    check_eq("t6_out", 32'(w_outc), 1);

    // Asynchronous reset in the middle of a step
    @(negedge clk);
    r_next = 1'b1;
    @(posedge clk);
    #2 r_reset = 1'b0;
    #1;
    check_eq("t6_async_state", 32'(w_stc), 0);
    check_eq("t6_async_out", 32'(w_outc), 0);
    check_eq("t6_async_cnt", 32'(w_cntc), 0);
    @(negedge clk);
    r_next  = 1'b0;
    r_reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
